// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
//   Shared types and helpers for the Pong score/game-flow controller.
//   - state_e : game state encoding, also driven out on game_state
//               (IDLE=0, PLAY=1, SERVE=2, OVER=3)
//   - bcd2_t  : a two-digit BCD score {tens, ones}
//   - toBcd2  : integer -> two-digit BCD, used at elaboration to split
//               WIN_SCORE into its tens/ones constants
//   - bcd2Inc : two-digit BCD increment (ones 9 -> 0 carries into tens)
// ---------------------------------------------------------------------------
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_SERVE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    // Only meaningful for 0..99; the win score is constrained to 1..99.
    function automatic bcd2_t toBcd2(input int unsigned value);
        bcd2_t result;
        result.tens = 4'((value / 10) % 10);
        result.ones = 4'(value % 10);
        return result;
    endfunction

    // Tens wrap 9 -> 0 only for completeness; the game ends at the win
    // score, so a live score never reaches that case.
    function automatic bcd2_t bcd2Inc(input bcd2_t value);
        bcd2_t result;
        if (value.ones == 4'd9) begin
            result.ones = 4'd0;
            result.tens = (value.tens == 4'd9) ? 4'd0 : value.tens + 4'd1;
        end else begin
            result.ones = value.ones + 4'd1;
            result.tens = value.tens;
        end
        return result;
    endfunction

endpackage

// File: rtl/pong_bcd2_counter.sv
// ---------------------------------------------------------------------------
// pong_bcd2_counter
//   Two-digit BCD up-counter holding one player's score.
//   Ports:
//     clk    in   system clock
//     reset  in   synchronous, active-high reset (clears to 00)
//     clr    in   synchronous clear, has priority over inc
//     inc    in   add one point this cycle
//     tens   out  tens digit, BCD
//     ones   out  ones digit, BCD
// ---------------------------------------------------------------------------
module pong_bcd2_counter
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    bcd2_t count_q;
    bcd2_t count_d;

    // Next count: clear wins over increment so a new game always starts at 00.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = bcd2Inc(count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tens = count_q.tens;
    assign ones = count_q.ones;

endmodule

// File: rtl/pong_score_ctrl.sv
// ---------------------------------------------------------------------------
// pong_score_ctrl
//   Game-flow controller and two-player BCD score keeper for the Pong
//   display path. Feeds the text overlay stage with score digits and
//   region enables, and freezes the ball outside of PLAY.
//   Parameters:
//     WIN_SCORE    points needed to win (1..99)
//     SERVE_FRAMES refr_tick pulses spent in SERVE before the ball moves
//     TMR_W        serve timer width, SERVE_FRAMES < 2**TMR_W
//   Ports:
//     clk          in   system clock
//     reset        in   synchronous, active-high reset
//     btn_start    in   debounced start button level
//     refr_tick    in   one-cycle pulse per video frame
//     p1_point     in   one-cycle pulse, P1 scores
//     p2_point     in   one-cycle pulse, P2 scores
//     dig0/dig1    out  P1 ones/tens, BCD
//     dig2/dig3    out  P2 ones/tens, BCD
//     game_state   out  IDLE=0, PLAY=1, SERVE=2, OVER=3
//     graph_still  out  1 = ball frozen at centre
//     show_logo    out  logo region enable
//     show_rule    out  rule region enable
//     show_over    out  game-over region enable
//     winner       out  0 = P1, 1 = P2 (meaningful in OVER only)
// ---------------------------------------------------------------------------
module pong_score_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = 11,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned TMR_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       refr_tick,
    input  logic       p1_point,
    input  logic       p2_point,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic [1:0] game_state,
    output logic       graph_still,
    output logic       show_logo,
    output logic       show_rule,
    output logic       show_over,
    output logic       winner
);

    localparam bcd2_t            WIN_BCD    = toBcd2(WIN_SCORE);
    localparam logic [TMR_W-1:0] SERVE_LAST = TMR_W'(SERVE_FRAMES - 1);

    state_e             state_q;
    state_e             state_d;
    logic [TMR_W-1:0]   timer_q;
    logic [TMR_W-1:0]   timer_d;
    logic               winner_q;
    logic               winner_d;
    logic               btnPrev_q;

    logic               startEdge;
    logic               clrScores;
    logic               incP1;
    logic               incP2;
    logic [3:0]         p1Tens;
    logic [3:0]         p1Ones;
    logic [3:0]         p2Tens;
    logic [3:0]         p2Ones;
    bcd2_t              p1Next;
    bcd2_t              p2Next;

    // btnPrev_q resets to 1 so a button held through reset is not a press.
    assign startEdge = btn_start & ~btnPrev_q;

    // The win check looks at the score as it will be after this point,
    // so the state change lands in the same cycle as the digit update.
    assign p1Next = bcd2Inc({p1Tens, p1Ones});
    assign p2Next = bcd2Inc({p2Tens, p2Ones});

    pong_bcd2_counter u_p1Score (
        .clk   (clk),
        .reset (reset),
        .clr   (clrScores),
        .inc   (incP1),
        .tens  (p1Tens),
        .ones  (p1Ones)
    );

    pong_bcd2_counter u_p2Score (
        .clk   (clk),
        .reset (reset),
        .clr   (clrScores),
        .inc   (incP2),
        .tens  (p2Tens),
        .ones  (p2Ones)
    );

    // Game flow. Points only count in PLAY; when both players score in the
    // same cycle P1 is taken and P2 is dropped. Start presses only matter in
    // IDLE (begin a game) and OVER (back to the title screen).
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        winner_d  = winner_q;
        clrScores = 1'b0;
        incP1     = 1'b0;
        incP2     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (startEdge) begin
                    clrScores = 1'b1;
                    timer_d   = '0;
                    state_d   = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (refr_tick) begin
                    if (timer_q == SERVE_LAST) begin
                        timer_d = '0;
                        state_d = ST_PLAY;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (p1_point) begin
                    incP1 = 1'b1;
                    if (p1Next == WIN_BCD) begin
                        winner_d = 1'b0;
                        state_d  = ST_OVER;
                    end else begin
                        timer_d = '0;
                        state_d = ST_SERVE;
                    end
                end else if (p2_point) begin
                    incP2 = 1'b1;
                    if (p2Next == WIN_BCD) begin
                        winner_d = 1'b1;
                        state_d  = ST_OVER;
                    end else begin
                        timer_d = '0;
                        state_d = ST_SERVE;
                    end
                end
            end
            ST_OVER: begin
                if (startEdge) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            winner_q  <= 1'b0;
            btnPrev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            winner_q  <= winner_d;
            btnPrev_q <= btn_start;
        end
    end

    assign dig0        = p1Ones;
    assign dig1        = p1Tens;
    assign dig2        = p2Ones;
    assign dig3        = p2Tens;
    assign game_state  = state_q;
    assign graph_still = (state_q != ST_PLAY);
    assign show_logo   = (state_q == ST_IDLE);
    assign show_rule   = (state_q == ST_IDLE);
    assign show_over   = (state_q == ST_OVER);
    assign winner      = winner_q;

endmodule

// File: tb/tb_pong_score_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pong_score_ctrl
//   Self-checking bench for pong_score_ctrl. Each driven cycle advances a
//   small integer game model; its predicted outputs go into a queue and are
//   popped and compared once the DUT has clocked that cycle.
// ---------------------------------------------------------------------------
module tb_pong_score_ctrl;

    localparam int WIN = 11;
    localparam int SF  = 60;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_start;
    logic       refr_tick;
    logic       p1_point;
    logic       p2_point;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic [3:0] dig3;
    logic [1:0] game_state;
    logic       graph_still;
    logic       show_logo;
    logic       show_rule;
    logic       show_over;
    logic       winner;

    typedef struct packed {
        logic [15:0] digits;
        logic [1:0]  st;
        logic        still;
        logic        logo;
        logic        rule;
        logic        over;
        logic        win;
    } expect_t;

    expect_t scoreQ[$];
    int total = 0;
    int bad   = 0;

    // Game model: 0=IDLE 1=PLAY 2=SERVE 3=OVER, scores kept as integers.
    int mState   = 0;
    int mP1      = 0;
    int mP2      = 0;
    int mTimer   = 0;
    int mWinner  = 0;
    int mBtnPrev = 1;

    always #5 clk = ~clk;

    pong_score_ctrl #(
        .WIN_SCORE    (WIN),
        .SERVE_FRAMES (SF),
        .TMR_W        (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_start   (btn_start),
        .refr_tick   (refr_tick),
        .p1_point    (p1_point),
        .p2_point    (p2_point),
        .dig0        (dig0),
        .dig1        (dig1),
        .dig2        (dig2),
        .dig3        (dig3),
        .game_state  (game_state),
        .graph_still (graph_still),
        .show_logo   (show_logo),
        .show_rule   (show_rule),
        .show_over   (show_over),
        .winner      (winner)
    );

    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)",
                     tag, actual, expected, $time);
        end
    endtask

    task automatic modelStep(input logic rst, input logic btn, input logic tick,
                             input logic p1, input logic p2);
        logic startEdge;
        if (rst) begin
            mState = 0; mP1 = 0; mP2 = 0; mTimer = 0; mWinner = 0; mBtnPrev = 1;
        end else begin
            startEdge = btn && (mBtnPrev == 0);
            mBtnPrev  = btn ? 1 : 0;
            case (mState)
                0: if (startEdge) begin
                    mP1 = 0; mP2 = 0; mTimer = 0; mState = 2;
                end
                2: if (tick) begin
                    if (mTimer == SF - 1) begin
                        mTimer = 0; mState = 1;
                    end else begin
                        mTimer++;
                    end
                end
                1: begin
                    if (p1) begin
                        mP1++;
                        if (mP1 == WIN) begin mState = 3; mWinner = 0; end
                        else begin mState = 2; mTimer = 0; end
                    end else if (p2) begin
                        mP2++;
                        if (mP2 == WIN) begin mState = 3; mWinner = 1; end
                        else begin mState = 2; mTimer = 0; end
                    end
                end
                default: if (startEdge) mState = 0;
            endcase
        end
    endtask

    task automatic pushExpected();
        expect_t e;
        e.digits = {4'(mP2 / 10), 4'(mP2 % 10), 4'(mP1 / 10), 4'(mP1 % 10)};
        e.st     = 2'(mState);
        e.still  = (mState != 1);
        e.logo   = (mState == 0);
        e.rule   = (mState == 0);
        e.over   = (mState == 3);
        e.win    = (mWinner != 0);
        scoreQ.push_back(e);
    endtask

    task automatic compareCycle();
        expect_t e;
        if (scoreQ.size() == 0) begin
            checkOutput("queue_empty", 16'(scoreQ.size()), 16'd1);
        end else begin
            e = scoreQ.pop_front();
            checkOutput("digits", {dig3, dig2, dig1, dig0}, e.digits);
            checkOutput("state", 16'(game_state), 16'(e.st));
            checkOutput("graph_still", 16'(graph_still), 16'(e.still));
            checkOutput("show_logo", 16'(show_logo), 16'(e.logo));
            checkOutput("show_rule", 16'(show_rule), 16'(e.rule));
            checkOutput("show_over", 16'(show_over), 16'(e.over));
            if (e.st == 2'd3) begin
                checkOutput("winner", 16'(winner), 16'(e.win));
            end
        end
    endtask

    // One clock of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus(input logic rst, input logic btn, input logic tick,
                                 input logic p1, input logic p2);
        reset     = rst;
        btn_start = btn;
        refr_tick = tick;
        p1_point  = p1;
        p2_point  = p2;
        modelStep(rst, btn, tick, p1, p2);
        pushExpected();
        @(posedge clk);
        #1;
        compareCycle();
    endtask

    task automatic pressStart();
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic serve();
        for (int i = 0; i < SF; i++) applyStimulus(0, 0, 1, 0, 0);
    endtask

    // Slow serve with dropped ticks, points and a start press that must all be ignored.
    task automatic noisyServe();
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < SF; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            applyStimulus(0, 0, 1, (i == 30), 0);
        end
    endtask

    initial begin
        reset = 1'b1; btn_start = 1'b1; refr_tick = 1'b0;
        p1_point = 1'b0; p2_point = 1'b0;

        // Reset with button held: no game start until a real rising edge.
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 0);
        pressStart();
        noisyServe();

        // P1 runs to 10 (one point scored together with P2), P2 to 3.
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(0, 0, 0, 1, (k == 5));
            serve();
            if (k <= 3) begin
                applyStimulus(0, 0, 0, 0, 1);
                serve();
            end
        end

        // Winning point for P1, then ignored inputs in OVER.
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 1);
        // Back to IDLE with 11:03 still shown, then a new game clears it.
        pressStart();
        applyStimulus(0, 0, 1, 1, 1);
        pressStart();
        serve();

        // P2 wins 11:0.
        for (int k = 1; k <= WIN; k++) begin
            applyStimulus(0, 0, 0, 0, 1);
            serve();
        end

        // Fresh game to 3:5, then reset in the middle of PLAY.
        pressStart();
        pressStart();
        serve();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 0, 0, (k < 3), (k >= 3));
            serve();
        end
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pong_score_ctrl.md
Name: pong_score_ctrl

Overview:
Game-flow controller and two-player BCD score keeper for the Pong display path.
- Consumes point events from the ball/graph logic and the start button.
- Produces the four score digits (dig0..dig3), the ball freeze signal, and the region enables for the text renderer (logo, rule, game-over).
- Sits directly upstream of the text overlay stage, which converts the digits to ASCII.

Parameters:
- WIN_SCORE, 11, points needed to win; legal range 1..99; split into tens/ones BCD constants at elaboration.
- SERVE_FRAMES, 60, number of refr_tick pulses to wait in SERVE before the ball is released.
- TMR_W, 8, serve timer width; must satisfy SERVE_FRAMES < 2**TMR_W.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_start  in  1  start button level, already debounced
- refr_tick  in  1  one-cycle pulse per video frame
- p1_point  in  1  one-cycle pulse: P1 scores
- p2_point  in  1  one-cycle pulse: P2 scores
- dig0  out  4  P1 ones digit, BCD
- dig1  out  4  P1 tens digit, BCD
- dig2  out  4  P2 ones digit, BCD
- dig3  out  4  P2 tens digit, BCD
- game_state  out  2  IDLE=0, PLAY=1, SERVE=2, OVER=3
- graph_still  out  1  1 = ball frozen at centre
- show_logo  out  1  logo region enable
- show_rule  out  1  rule region enable
- show_over  out  1  game-over region enable
- winner  out  1  0 = P1, 1 = P2; valid only in OVER

Behaviour:
- Clock and reset
  - One clock; reset is synchronous and active-high. Ports are named clk and reset.
  - Reset forces: state = IDLE, all digits = 0, timer = 0, winner = 0, btn_prev = 1.
  - btn_prev = 1 ensures a button held through reset does not start a game.
- All outputs are registered, or decoded from registered state only.
- Start edge: start_edge = btn_start & ~btn_prev. btn_prev updates every cycle.
- IDLE
  - graph_still = 1, show_logo = 1, show_rule = 1.
  - On start_edge: clear all four digits and go to SERVE, with timer = 0.
- SERVE
  - graph_still = 1.
  - Timer increments on each refr_tick.
  - When the timer equals SERVE_FRAMES-1 and refr_tick is high, go to PLAY and clear the timer.
  - Point pulses are ignored.
- PLAY
  - graph_still = 0.
  - On a point pulse, increment that player's two-digit BCD counter:
    - ones 9 -> 0 with a carry into tens;
    - otherwise ones + 1.
  - If the new value equals WIN_SCORE (BCD compare): go to OVER and set winner (0 for P1, 1 for P2).
  - Otherwise go to SERVE with timer = 0.
- Simultaneous points: if p1_point and p2_point are high in the same cycle, P1 is processed and P2 is dropped.
- Point latency: a pulse in cycle n gives updated digits and state in cycle n+1.
- OVER
  - graph_still = 1, show_over = 1.
  - Digits and winner hold.
  - On start_edge: go to IDLE. Digits hold until the next IDLE start.
- Ignored inputs: point pulses outside PLAY, and start_edge in PLAY or SERVE.
- Range: a digit never exceeds 9, and a score never exceeds 99 (guaranteed by WIN_SCORE <= 99).
- Reset mid-game: returns to IDLE within one cycle; scores are lost.

Decomposition:
- Package pong_pkg holds:
  - state encoding localparams ST_IDLE, ST_PLAY, ST_SERVE, ST_OVER;
  - WIN_TENS/WIN_ONES derivation function.
- Sub-module pong_bcd2_counter: ports clk, reset, clr, inc, tens[3:0], ones[3:0].
  - Synchronous clear with priority over inc.
  - Instantiated twice, once per player.

Test Plan:
- Reset with btn_start held high, then release and press again → state stays IDLE until the second rising edge; digits 0000; show_logo = show_rule = 1.
- Start, then 59 refr_ticks → still SERVE; 60th tick → PLAY and graph_still = 0 on the next cycle.
- Ten p1_point pulses, each followed by a serve → dig1:dig0 goes 0:9 then 1:0; state returns to SERVE after each point.
- With P1 at 10, one more p1_point → dig1:dig0 = 1:1, state OVER, winner = 0, show_over = 1. A further btn_start edge → IDLE, with 1:1 still shown until the next start clears it.
- p1_point and p2_point in the same cycle in PLAY → P1 +1, P2 unchanged. Point pulses during SERVE → no change.
- Assert reset during PLAY with scores 3:5 → next cycle IDLE, all digits 0, graph_still = 1.
